lattice_validator_multi: RTL and testbench

LATTICE_VALIDATOR_MULTI -- requirements
Module: lattice_validator_multi

---
 rtl/lattice_validator_multi_pkg.sv | 33 +++
 rtl/lattice_validator_multi_if.sv | 30 +++
 rtl/lattice_validator_multi_lzc256.sv | 35 +++
 rtl/lattice_validator_multi.sv | 113 +++++++++++
 tb/tb_lattice_validator_multi.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/lattice_validator_multi_pkg.sv
// lattice_pkg: shared widths, lane hash type and leading-zero count helpers.
package lattice_pkg;
  localparam int HASH_W = 256;
  localparam int DIFF_W = 32;
  localparam int DROP_W = 16;
  localparam int CNT_W = 9;
  localparam int CHUNKS = HASH_W / 16;
  typedef logic [HASH_W-1:0] lane_hash_t;
  typedef logic [CHUNKS-1:0][4:0] chunk_cnt_t;
  function automatic logic [4:0] lzc16(input logic [15:0] x);
    logic [4:0] n;
    logic done;
    n = '0;
    done = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      done = done | x[i];
      n = n + {4'd0, ~done};
    end
    return n;
  endfunction
  // Chunk CHUNKS-1 holds the hash MSBs; counting stops at the first chunk that is not all zero.
  function automatic logic [CNT_W-1:0] lzc_merge(input chunk_cnt_t c);
    logic [CNT_W-1:0] n;
    logic done;
    n = '0;
    done = 1'b0;
    for (int i = CHUNKS - 1; i >= 0; i--) begin
      if (!done) n = n + CNT_W'(c[i]);
      done = done | (c[i] != 5'd16);
    end
    return n;
  endfunction
endpackage

// File: rtl/lattice_validator_multi_if.sv
// lattice_validator_multi_if: beat input, compare result and result-register handshake bundle.
interface lattice_validator_multi_if #(
  parameter int LANES = 4,
  parameter int COUNTBITS = 6
);
  import lattice_pkg::*;
  logic                    valid_i;
  logic                    newblock_i;
  logic [LANES*HASH_W-1:0] hash_i;
  logic [DIFF_W-1:0]       difficulty_i;
  logic                    valid_o;
  logic                    newblock_o;
  logic                    success_o;
  logic [COUNTBITS-1:0]    nonce_prefix_o;
  logic                    res_valid_o;
  logic [COUNTBITS-1:0]    res_prefix_o;
  logic                    res_ready_i;
  logic                    block_found_o;
  logic [DROP_W-1:0]       drop_count_o;
  modport slave (
    input  valid_i, newblock_i, hash_i, difficulty_i, res_ready_i,
    output valid_o, newblock_o, success_o, nonce_prefix_o,
    output res_valid_o, res_prefix_o, block_found_o, drop_count_o
  );
  modport master (
    output valid_i, newblock_i, hash_i, difficulty_i, res_ready_i,
    input  valid_o, newblock_o, success_o, nonce_prefix_o,
    input  res_valid_o, res_prefix_o, block_found_o, drop_count_o
  );
endinterface

// File: rtl/lattice_validator_multi_lzc256.sv
// lattice_lzc256: 256-bit leading-zero counter with STAGES registered stages.
module lattice_lzc256 import lattice_pkg::*; #(
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  lane_hash_t       hash_i,
  output logic [CNT_W-1:0] count_o
);
  chunk_cnt_t chunk_d, chunk_s;
  logic [CNT_W-1:0] count_q;
  always_comb begin
    chunk_d = '0;
    for (int c = 0; c < CHUNKS; c++) chunk_d[c] = lzc16(hash_i[16*c +: 16]);
  end
  // Per-chunk counts are computed up front; extra stages only carry them to the final merge.
  if (STAGES > 1) begin : g_dly
    chunk_cnt_t [STAGES-2:0] dly_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) dly_q <= '0;
      else begin
        dly_q[0] <= chunk_d;
        for (int s = 1; s < STAGES - 1; s++) dly_q[s] <= dly_q[s-1];
      end
    end
    assign chunk_s = dly_q[STAGES-2];
  end else begin : g_nodly
    assign chunk_s = chunk_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else count_q <= lzc_merge(chunk_s);
  end
  assign count_o = count_q;
endmodule

// File: rtl/lattice_validator_multi.sv
// lattice_validator_multi: multi-lane difficulty check with a single-entry result register.
module lattice_validator_multi import lattice_pkg::*; #(
  parameter int LANES = 4,
  parameter int COUNTBITS = 6,
  parameter int INDEX = 0,
  parameter int CMP_STAGES = 2
) (
  input logic clk,
  input logic rst,
  lattice_validator_multi_if.slave bus
);
  localparam int L = CMP_STAGES - 1;
  if (INDEX * LANES + LANES - 1 >= (1 << COUNTBITS)) begin : g_bad_prefix
    $error("nonce prefix range does not fit in COUNTBITS");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("LANES must be 1..16");
  end
  if (CMP_STAGES < 1 || CMP_STAGES > 4) begin : g_bad_stages
    $error("CMP_STAGES must be 1..4");
  end
  lane_hash_t [LANES-1:0] lane_hash;
  logic [LANES-1:0][CNT_W-1:0] cnt;
  assign lane_hash = bus.hash_i;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lattice_lzc256 #(.STAGES(CMP_STAGES)) u_lzc (
      .clk    (clk),
      .rst    (rst),
      .hash_i (lane_hash[k]),
      .count_o(cnt[k])
    );
  end
  logic [CMP_STAGES-1:0] v_q, nb_q;
  logic [CMP_STAGES-1:0][DIFF_W-1:0] diff_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      nb_q <= '0;
      diff_q <= '0;
    end else begin
      v_q[0] <= bus.valid_i;
      nb_q[0] <= bus.newblock_i;
      diff_q[0] <= bus.difficulty_i;
      for (int s = 1; s < CMP_STAGES; s++) begin
        v_q[s] <= v_q[s-1];
        nb_q[s] <= nb_q[s-1];
        diff_q[s] <= diff_q[s-1];
      end
    end
  end
  // Descending scan so the lowest succeeding lane is the last to write win.
  logic [LANES-1:0] hit;
  logic [COUNTBITS-1:0] win;
  always_comb begin
    hit = '0;
    win = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      hit[k] = v_q[L] && (DIFF_W'(cnt[k]) >= diff_q[L]);
      if (hit[k]) win = COUNTBITS'(k);
    end
  end
  logic valid_d, newblock_d, success_d;
  logic [COUNTBITS-1:0] prefix_d;
  logic valid_q, newblock_q, success_q;
  logic [COUNTBITS-1:0] prefix_q;
  assign valid_d = v_q[L];
  assign newblock_d = v_q[L] & nb_q[L];
  assign success_d = |hit;
  assign prefix_d = success_d ? COUNTBITS'(INDEX * LANES) + win : '0;
  logic pop, flush, fire, load;
  logic res_valid_d, res_valid_q, found_d, found_q;
  logic [COUNTBITS-1:0] res_prefix_d, res_prefix_q;
  logic [DROP_W-1:0] drop_d, drop_q;
  assign pop = res_valid_q & bus.res_ready_i;
  assign flush = valid_q & newblock_q;
  assign fire = valid_q & success_q;
  assign load = fire & (~res_valid_q | pop | flush);
  always_comb begin
    res_valid_d = load | (res_valid_q & ~pop & ~flush);
    res_prefix_d = load ? prefix_q : res_prefix_q;
    found_d = load | (found_q & ~flush);
    drop_d = (fire && !load && drop_q != '1) ? drop_q + DROP_W'(1) : drop_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      newblock_q <= 1'b0;
      success_q <= 1'b0;
      prefix_q <= '0;
      res_valid_q <= 1'b0;
      res_prefix_q <= '0;
      found_q <= 1'b0;
      drop_q <= '0;
    end else begin
      valid_q <= valid_d;
      newblock_q <= newblock_d;
      success_q <= success_d;
      prefix_q <= prefix_d;
      res_valid_q <= res_valid_d;
      res_prefix_q <= res_prefix_d;
      found_q <= found_d;
      drop_q <= drop_d;
    end
  end
  assign bus.valid_o = valid_q;
  assign bus.newblock_o = newblock_q;
  assign bus.success_o = success_q;
  assign bus.nonce_prefix_o = prefix_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_prefix_o = res_prefix_q;
  assign bus.block_found_o = found_q;
  assign bus.drop_count_o = drop_q;
endmodule

// File: tb/tb_lattice_validator_multi.sv
// tb_lattice_validator_multi: scoreboard bench with a leading-zero reference model.
module tb_lattice_validator_multi;
  import lattice_pkg::*;
  localparam int LANES = 4;
  localparam int COUNTBITS = 6;
  localparam int INDEX = 2;
  localparam int CMP_STAGES = 2;
  localparam int LAT = CMP_STAGES + 1;
  typedef struct {
    int due;
    bit nb;
    bit succ;
    logic [COUNTBITS-1:0] pre;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  exp_t sb[$];
  bit m_v, m_found;
  logic [COUNTBITS-1:0] m_p;
  int m_drop;
  lane_hash_t ONES, ZERO;
  lattice_validator_multi_if #(.LANES(LANES), .COUNTBITS(COUNTBITS)) bus();
  lattice_validator_multi #(
    .LANES(LANES), .COUNTBITS(COUNTBITS), .INDEX(INDEX), .CMP_STAGES(CMP_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask
  function automatic lane_hash_t lzh(input int n);
    lane_hash_t h;
    if (n >= 256) return '0;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    h = h >> n;
    h[255-n] = 1'b1;
    return h;
  endfunction
  function automatic exp_t ref_beat(input logic [LANES*256-1:0] hv, input logic [31:0] d, input bit nb);
    exp_t e;
    e.due = cyc + LAT;
    e.nb = nb;
    e.succ = 1'b0;
    e.pre = '0;
    for (int k = 0; k < LANES && !e.succ; k++) begin
      lane_hash_t h;
      int unsigned lz;
      h = hv[256*k +: 256];
      lz = 0;
      while (lz < 256 && h[255-lz] == 1'b0) lz++;
      if (lz >= d) begin
        e.succ = 1'b1;
        e.pre = COUNTBITS'(INDEX * LANES + k);
      end
    end
    return e;
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [LANES*256-1:0] hv, input logic [31:0] d, input bit nb);
    bus.valid_i = 1'b1;
    bus.hash_i = hv;
    bus.difficulty_i = d;
    bus.newblock_i = nb;
    sb.push_back(ref_beat(hv, d, nb));
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.newblock_i = 1'b0;
    bus.difficulty_i = $urandom;
    bus.hash_i = {LANES{lzh(0)}};
  endtask
  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    bit have, pop;
    if (!rst) begin
      chk("reset_outputs", 64'({bus.valid_o, bus.newblock_o, bus.success_o, bus.nonce_prefix_o,
          bus.res_valid_o, bus.res_prefix_o, bus.block_found_o, bus.drop_count_o}), 64'(0));
      sb.delete();
      m_v = 1'b0;
      m_p = '0;
      m_found = 1'b0;
      m_drop = 0;
    end else begin
      have = 1'b0;
      if (bus.valid_o || (sb.size() > 0 && sb[0].due <= cyc)) begin
        if (sb.size() == 0) chk("unexpected_valid_o", 64'(bus.valid_o), 64'(0));
        else begin
          e = sb.pop_front();
          have = 1'b1;
          chk("beat", 64'({bus.valid_o, bus.newblock_o, bus.success_o, bus.nonce_prefix_o, 32'(cyc)}),
              64'({1'b1, e.nb, e.succ, e.pre, 32'(e.due)}));
        end
      end else chk("idle_gating", 64'({bus.success_o, bus.newblock_o}), 64'(0));
      chk("res_state", 64'({bus.res_valid_o, bus.block_found_o, bus.drop_count_o}),
          64'({m_v, m_found, 16'(m_drop)}));
      if (m_v) chk("res_prefix", 64'(bus.res_prefix_o), 64'(m_p));
      pop = m_v && bus.res_ready_i;
      if (pop || (have && e.nb)) m_v = 1'b0;
      if (have && e.nb) m_found = 1'b0;
      if (have && e.succ) begin
        if (!m_v) begin
          m_v = 1'b1;
          m_p = e.pre;
          m_found = 1'b1;
        end else if (m_drop < 65535) m_drop++;
      end
    end
  end
  initial begin
    logic [LANES*256-1:0] hv;
    logic [31:0] d;
    ONES = '1;
    ZERO = '0;
    bus.valid_i = 1'b0;
    bus.newblock_i = 1'b0;
    bus.res_ready_i = 1'b0;
    bus.hash_i = '0;
    bus.difficulty_i = '0;
    idle(3);
    rst = 1'b1;
    idle(2);
    send({ONES, ONES, {8'h00, {248{1'b1}}}, ONES}, 32'd8, 1'b0);
    idle(4);
    chk("directed_capture", 64'({bus.res_valid_o, bus.res_prefix_o}), 64'({1'b1, 6'd9}));
    bus.res_ready_i = 1'b1;
    send({lzh(12), ONES, lzh(10), ONES}, 32'd10, 1'b0);
    send({ONES, ONES, ONES, ONES}, 32'd0, 1'b0);
    send({ZERO, ZERO, ZERO, ZERO}, 32'd257, 1'b0);
    send({ZERO, ZERO, ZERO, ZERO}, 32'd256, 1'b0);
    send({lzh(31), lzh(32), lzh(30), lzh(20)}, 32'd32, 1'b0);
    idle(5);
    bus.res_ready_i = 1'b0;
    do_reset();
    idle(1);
    send({ONES, ONES, ONES, lzh(5)}, 32'd5, 1'b0);
    send({ONES, ONES, lzh(5), ONES}, 32'd5, 1'b0);
    send({ONES, lzh(5), ONES, ONES}, 32'd5, 1'b0);
    idle(5);
    chk("drop_two", 64'({bus.drop_count_o, bus.res_prefix_o}), 64'({16'd2, 6'd8}));
    bus.res_ready_i = 1'b1;
    idle(1);
    bus.res_ready_i = 1'b0;
    chk("pop_clears", 64'(bus.res_valid_o), 64'(0));
    send({ONES, ONES, lzh(7), ONES}, 32'd7, 1'b0);
    idle(4);
    send({ONES, lzh(9), ONES, ONES}, 32'd9, 1'b1);
    idle(4);
    chk("newblock_reload", 64'({bus.drop_count_o, bus.res_valid_o, bus.res_prefix_o, bus.block_found_o}),
        64'({16'd2, 1'b1, 6'd10, 1'b1}));
    send({ONES, ONES, ONES, ONES}, 32'd40, 1'b1);
    idle(4);
    chk("newblock_clear", 64'({bus.res_valid_o, bus.block_found_o}), 64'(0));
    send({ONES, lzh(3), ONES, ONES}, 32'd3, 1'b0);
    idle(4);
    send({lzh(3), ONES, ONES, ONES}, 32'd3, 1'b0);
    idle(2);
    bus.res_ready_i = 1'b1;
    idle(1);
    bus.res_ready_i = 1'b0;
    chk("pop_and_load", 64'({bus.drop_count_o, bus.res_valid_o, bus.res_prefix_o}),
        64'({16'd2, 1'b1, 6'd11}));
    send({ONES, ONES, ONES, lzh(4)}, 32'd4, 1'b0);
    send({ONES, ONES, lzh(4), ONES}, 32'd4, 1'b0);
    send({ONES, lzh(4), ONES, ONES}, 32'd4, 1'b0);
    do_reset();
    idle(6);
    chk("post_reset_quiet", 64'({bus.valid_o, bus.res_valid_o, bus.drop_count_o}), 64'(0));
    send({ONES, ONES, lzh(2), ONES}, 32'd2, 1'b0);
    idle(5);
    for (int i = 0; i < 400; i++) begin
      bus.res_ready_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) == 0) idle(1);
      else begin
        case ($urandom_range(0, 19))
          0: d = 32'd256;
          1: d = 32'd257;
          2: d = $urandom;
          default: d = $urandom_range(0, 24);
        endcase
        for (int k = 0; k < LANES; k++)
          hv[256*k +: 256] = lzh(($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(0, 28)));
        send(hv, d, ($urandom_range(0, 9) == 0));
      end
    end
    bus.res_ready_i = 1'b0;
    idle(8);
    chk("drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
